// File: rtl/quad_decoder.sv
// Quadrature encoder front-end: 2-flop sync + per-channel debounce, Gray-sequence
// tracking, and a registered step/direction/error output for the up/down counter.
module quad_decoder #(
    parameter int DB = 4,
    parameter bit X4 = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic en,
    output logic updown,
    output logic err
);
    localparam int CW = $clog2(DB + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB - 1);

    // Channel index 1 = A, 0 = B, so the packed vectors read as {a,b}.
    logic [1:0]         raw;
    logic [1:0]         s1_q, s1_d, s2_q, s2_d, f_q, f_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;
    logic [1:0]         prev_q, prev_d;
    logic               en_q, en_d, updown_q, updown_d, err_q, err_d;
    logic [1:0]         diff;
    logic               step;

    assign raw = {a, b};

    // Position along the forward sequence 00->10->11->01.
    function automatic logic [1:0] gidx(input logic [1:0] ab);
        case (ab)
            2'b00:   gidx = 2'd0;
            2'b10:   gidx = 2'd1;
            2'b11:   gidx = 2'd2;
            default: gidx = 2'd3;
        endcase
    endfunction

    always_comb begin
        s1_d  = raw;
        s2_d  = s1_q;
        f_d   = f_q;
        cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != f_q[i]) begin
                if (cnt_q[i] == CNT_LAST) f_d[i] = s2_q[i];
                else                      cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // diff 1 = forward step, 3 = reverse step, 2 = both channels moved.
    always_comb begin
        prev_d   = f_q;
        diff     = gidx(f_q) - gidx(prev_q);
        step     = (diff == 2'd1) || (diff == 2'd3);
        en_d     = step && (X4 || (f_q == 2'b00));
        updown_d = en_d ? (diff == 2'd3) : updown_q;
        err_d    = (diff == 2'd2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= '0;
            s2_q     <= '0;
            f_q      <= '0;
            cnt_q    <= '0;
            prev_q   <= '0;
            en_q     <= 1'b0;
            updown_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            f_q      <= f_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            en_q     <= en_d;
            updown_q <= updown_d;
            err_q    <= err_d;
        end
    end

    assign en     = en_q;
    assign updown = updown_q;
    assign err    = err_q;
endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder: x4 and x1 modes at DB=4 plus a DB=1 instance,
// pulse counting on the falling edge and a 4-bit up/down counter driven by the x4 outputs.
module tb_quad_decoder;
    logic clk = 1'b0;
    logic rst, a, b;
    logic en1, up1, err1, en0, up0, err0, en2, up2, err2;

    always #5 clk = ~clk;

    quad_decoder #(.DB(4), .X4(1'b1)) u_x4 (.clk(clk), .rst(rst), .a(a), .b(b), .en(en1), .updown(up1), .err(err1));
    quad_decoder #(.DB(4), .X4(1'b0)) u_x1 (.clk(clk), .rst(rst), .a(a), .b(b), .en(en0), .updown(up0), .err(err0));
    quad_decoder #(.DB(1), .X4(1'b1)) u_db1 (.clk(clk), .rst(rst), .a(a), .b(b), .en(en2), .updown(up2), .err(err2));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0, n_pass = 0;
    int n_en1 = 0, n_en1_up = 0, n_err1 = 0, n_en0 = 0, n_en0_up = 0, n_en2 = 0;
    int n_both = 0, n_upd_bad = 0;
    int f_en1 = -1, f_en0 = -1, f_en2 = -1, f_err1 = -1;
    logic [3:0] q = '0;
    logic upd_prev = 1'b0;
    logic clr_req = 1'b0;
    int chg;

    // Falling-edge monitor; q models the counter attached to the x4 instance.
    always @(negedge clk) begin
        upd_prev <= up1;
        if (clr_req) begin
            n_en1 <= 0; n_en1_up <= 0; n_err1 <= 0; n_en0 <= 0; n_en0_up <= 0; n_en2 <= 0;
            f_en1 <= -1; f_en0 <= -1; f_en2 <= -1; f_err1 <= -1; q <= '0;
        end else if (!rst) begin
            if (en1) begin
                n_en1 <= n_en1 + 1;
                if (up1) n_en1_up <= n_en1_up + 1;
                if (f_en1 < 0) f_en1 <= cyc;
                q <= up1 ? q - 4'd1 : q + 4'd1;
            end
            if (en0) begin
                n_en0 <= n_en0 + 1;
                if (up0) n_en0_up <= n_en0_up + 1;
                if (f_en0 < 0) f_en0 <= cyc;
            end
            if (en2) begin
                n_en2 <= n_en2 + 1;
                if (f_en2 < 0) f_en2 <= cyc;
            end
            if (err1) begin
                n_err1 <= n_err1 + 1;
                if (f_err1 < 0) f_err1 <= cyc;
            end
            if ((en1 && err1) || (en0 && err0)) n_both <= n_both + 1;
            if (up1 != upd_prev && !en1) n_upd_bad <= n_upd_bad + 1;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic clr();
        @(posedge clk); #1 clr_req = 1'b1;
        @(negedge clk); #1 clr_req = 1'b0;
    endtask

    task automatic drive(input logic va, input logic vb, input int n);
        @(posedge clk); #1;
        a = va; b = vb; chg = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    int c0, c3;

    initial begin
        rst = 1'b1; a = 1'b1; b = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rst_x4_out", {en1, up1, err1}, 0);
        chk("rst_x1_out", {en0, up0, err0}, 0);
        @(posedge clk); #1 rst = 1'b0; a = 1'b0; b = 1'b0;
        repeat (12) @(posedge clk);
        chk("rst_en", n_en1 + n_en0 + n_en2, 0);
        chk("rst_err", n_err1, 0);
        chk("rst_updown", up1, 0);

        // Forward cycle
        clr();
        drive(1, 0, 10); c0 = chg;
        drive(1, 1, 10);
        drive(0, 1, 10);
        drive(0, 0, 10); c3 = chg;
        chk("fwd_en", n_en1, 4);
        chk("fwd_lat", f_en1 - c0, 7);
        chk("fwd_updown", n_en1_up, 0);
        chk("fwd_q", q, 4);
        chk("fwd_err", n_err1, 0);
        chk("x1_fwd_en", n_en0, 1);
        chk("x1_fwd_lat", f_en0 - c3, 7);
        chk("x1_fwd_updown", n_en0_up, 0);
        chk("db1_en", n_en2, 4);
        chk("db1_lat", f_en2 - c0, 4);

        // Reverse cycle
        clr();
        drive(0, 1, 10);
        drive(1, 1, 10);
        drive(1, 0, 10);
        drive(0, 0, 10);
        chk("rev_en", n_en1, 4);
        chk("rev_updown", n_en1_up, 4);
        chk("rev_q", q, 12);
        chk("rev_updown_hold", up1, 1);
        chk("x1_rev_en", n_en0, 1);
        chk("x1_rev_updown", n_en0_up, 1);

        // Glitch shorter than DB, then a stable rise
        clr();
        drive(1, 0, 3);
        drive(0, 0, 12);
        chk("glitch_en", n_en1, 0);
        chk("glitch_err", n_err1, 0);
        clr();
        drive(1, 0, 4);
        drive(1, 0, 10);
        chk("stable_en", n_en1, 1);
        chk("stable_updown", n_en1_up, 0);
        drive(0, 0, 12);

        // Both channels at once, then a legal move from 11
        clr();
        drive(1, 1, 12);
        chk("dbl_err", n_err1, 1);
        chk("dbl_lat", f_err1 - chg, 7);
        chk("dbl_en", n_en1, 0);
        clr();
        drive(0, 1, 12);
        chk("after_dbl_en", n_en1, 1);
        chk("after_dbl_updown", up1, 0);
        drive(0, 0, 12);

        // Reset while A is mid-debounce
        clr();
        @(posedge clk); #1 a = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0; a = 1'b0;
        repeat (12) @(posedge clk);
        chk("rst_mid_en", n_en1, 0);
        clr();
        drive(1, 0, 12);
        chk("post_rst_en", n_en1, 1);
        chk("post_rst_lat", f_en1 - chg, 7);
        drive(0, 0, 12);

        chk("en_err_overlap", n_both, 0);
        chk("updown_off_en", n_upd_bad, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
